// File: rtl/tetris_pkg.sv
// Shared board dimensions, colour encoding and arbiter state type
// for the playfield arbiter and its locked-cell store.
package tetris_pkg;

    localparam int unsigned ROWS_DEFAULT = 20;
    localparam int unsigned COLS_DEFAULT = 10;

    localparam logic [2:0] COLOR_EMPTY = 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOCK,
        SCAN,
        STEAL,
        WAIT_DROP,
        GAMEOVER
    } state_t;

endpackage

// File: rtl/playfield_store.sv
// Locked-cell store: ROWS x COLS colour array with four occupancy probes,
// a four-cell write, single-cycle row shift-down and a registered display port.
module playfield_store
    import tetris_pkg::*;
#(
    parameter int unsigned ROWS = ROWS_DEFAULT,
    parameter int unsigned COLS = COLS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0][4:0] q_h,
    input  logic [3:0][4:0] q_v,
    output logic [3:0]      q_occupied,
    input  logic            wr_en,
    input  logic [3:0][4:0] wr_h,
    input  logic [3:0][4:0] wr_v,
    input  logic [2:0]      wr_color,
    input  logic            shift_en,
    input  logic [4:0]      row_sel,
    output logic            row_full,
    input  logic [4:0]      disp_h,
    input  logic [4:0]      disp_v,
    output logic [2:0]      disp_color
);

    logic [COLS-1:0][2:0] field [ROWS];
    logic [2:0]           disp_next;

    // Out-of-bounds coordinates count as occupied so the arbiter sees one collision flag.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            q_occupied[i] = (q_h[i] >= 5'(ROWS)) || (q_v[i] >= 5'(COLS));
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    if (q_h[i] == 5'(r) && q_v[i] == 5'(c) && field[r][c] != COLOR_EMPTY)
                        q_occupied[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        row_full = 1'b0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_sel == 5'(r)) begin
                row_full = 1'b1;
                for (int unsigned c = 0; c < COLS; c++) begin
                    if (field[r][c] == COLOR_EMPTY)
                        row_full = 1'b0;
                end
            end
        end
    end

    always_comb begin
        disp_next = COLOR_EMPTY;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (disp_h == 5'(r) && disp_v == 5'(c))
                    disp_next = field[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < ROWS; r++)
                field[r] <= '0;
            disp_color <= '0;
        end else begin
            disp_color <= disp_next;
            if (shift_en) begin
                field[0] <= '0;
                for (int unsigned k = 1; k < ROWS; k++) begin
                    if (5'(k) <= row_sel)
                        field[k] <= field[k-1];
                end
            end else if (wr_en) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    for (int unsigned r = 0; r < ROWS; r++) begin
                        for (int unsigned c = 0; c < COLS; c++) begin
                            if (wr_h[i] == 5'(r) && wr_v[i] == 5'(c))
                                field[r][c] <= wr_color;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/playfield_arbiter.sv
// Answers active-piece movement requests against the locked playfield:
// commit, decline, or lock + line clear + steal; tracks lines and game over.
module playfield_arbiter
    import tetris_pkg::*;
#(
    parameter int unsigned ROWS = ROWS_DEFAULT,
    parameter int unsigned COLS = COLS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       movement_request,
    input  logic       movement_intent,
    input  logic [4:0] P1blk_v,
    input  logic [4:0] P2blk_v,
    input  logic [4:0] P3blk_v,
    input  logic [4:0] P4blk_v,
    input  logic [4:0] P1blk_h,
    input  logic [4:0] P2blk_h,
    input  logic [4:0] P3blk_h,
    input  logic [4:0] P4blk_h,
    input  logic [2:0] volatile_blk_color,
    output logic       movement_commit,
    output logic       movement_declined,
    output logic       movement_steal,
    input  logic [4:0] disp_v,
    input  logic [4:0] disp_h,
    output logic [2:0] disp_color,
    output logic [9:0] lines_cleared,
    output logic       game_over
);

    state_t          state;
    logic [3:0][4:0] cand_h;
    logic [3:0][4:0] cand_v;
    logic [3:0][4:0] saved_h;
    logic [3:0][4:0] saved_v;
    logic [2:0]      saved_color;
    logic            has_committed;
    logic [4:0]      scan_row;
    logic [3:0]      occupied;
    logic            collide;
    logic            row_full;
    logic            wr_en;
    logic            shift_en;

    always_comb begin
        cand_h   = {P4blk_h, P3blk_h, P2blk_h, P1blk_h};
        cand_v   = {P4blk_v, P3blk_v, P2blk_v, P1blk_v};
        collide  = |occupied;
        wr_en    = (state == LOCK);
        shift_en = (state == SCAN) && row_full;
    end

    playfield_store #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .q_h        (cand_h),
        .q_v        (cand_v),
        .q_occupied (occupied),
        .wr_en      (wr_en),
        .wr_h       (saved_h),
        .wr_v       (saved_v),
        .wr_color   (saved_color),
        .shift_en   (shift_en),
        .row_sel    (scan_row),
        .row_full   (row_full),
        .disp_h     (disp_h),
        .disp_v     (disp_v),
        .disp_color (disp_color)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            saved_h           <= '0;
            saved_v           <= '0;
            saved_color       <= '0;
            has_committed     <= 1'b0;
            scan_row          <= '0;
            movement_commit   <= 1'b0;
            movement_declined <= 1'b0;
            movement_steal    <= 1'b0;
            lines_cleared     <= '0;
            game_over         <= 1'b0;
        end else begin
            movement_commit   <= 1'b0;
            movement_declined <= 1'b0;
            movement_steal    <= 1'b0;
            case (state)
                IDLE: begin
                    if (movement_request)
                        state <= CHECK;
                end
                CHECK: begin
                    if (!collide) begin
                        movement_commit <= 1'b1;
                        saved_h         <= cand_h;
                        saved_v         <= cand_v;
                        saved_color     <= volatile_blk_color;
                        has_committed   <= 1'b1;
                        state           <= WAIT_DROP;
                    end else if (movement_intent) begin
                        movement_declined <= 1'b1;
                        state             <= WAIT_DROP;
                    end else if (has_committed) begin
                        state <= LOCK;
                    end else begin
                        game_over <= 1'b1;
                        state     <= GAMEOVER;
                    end
                end
                LOCK: begin
                    scan_row <= 5'(ROWS - 1);
                    state    <= SCAN;
                end
                SCAN: begin
                    // A cleared row keeps scan_row so the shifted-in row is checked too.
                    if (row_full)
                        lines_cleared <= lines_cleared + 10'd1;
                    else if (scan_row == 5'd0)
                        state <= STEAL;
                    else
                        scan_row <= scan_row - 5'd1;
                end
                STEAL: begin
                    movement_steal <= 1'b1;
                    has_committed  <= 1'b0;
                    state          <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    if (!movement_request)
                        state <= IDLE;
                end
                GAMEOVER: begin
                    state <= GAMEOVER;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_playfield_arbiter.sv
// Scenario-driven bench for playfield_arbiter; expected responses are queued
// when a request is issued and compared when the arbiter answers.
module tb_playfield_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       movement_request = 1'b0;
    logic       movement_intent = 1'b0;
    logic [4:0] P1blk_v = '0, P2blk_v = '0, P3blk_v = '0, P4blk_v = '0;
    logic [4:0] P1blk_h = '0, P2blk_h = '0, P3blk_h = '0, P4blk_h = '0;
    logic [2:0] volatile_blk_color = '0;
    logic       movement_commit, movement_declined, movement_steal;
    logic [4:0] disp_v = '0, disp_h = '0;
    logic [2:0] disp_color;
    logic [9:0] lines_cleared;
    logic       game_over;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    localparam int RSP_NONE     = 0;
    localparam int RSP_COMMIT   = 1;
    localparam int RSP_DECLINED = 2;
    localparam int RSP_STEAL    = 3;

    playfield_arbiter #(.ROWS(20), .COLS(10)) dut (
        .clk                (clk),
        .reset              (reset),
        .movement_request   (movement_request),
        .movement_intent    (movement_intent),
        .P1blk_v            (P1blk_v),
        .P2blk_v            (P2blk_v),
        .P3blk_v            (P3blk_v),
        .P4blk_v            (P4blk_v),
        .P1blk_h            (P1blk_h),
        .P2blk_h            (P2blk_h),
        .P3blk_h            (P3blk_h),
        .P4blk_h            (P4blk_h),
        .volatile_blk_color (volatile_blk_color),
        .movement_commit    (movement_commit),
        .movement_declined  (movement_declined),
        .movement_steal     (movement_steal),
        .disp_v             (disp_v),
        .disp_h             (disp_h),
        .disp_color         (disp_color),
        .lines_cleared      (lines_cleared),
        .game_over          (game_over)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        movement_request = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_piece(input logic [4:0] h1, v1, h2, v2, h3, v3, h4, v4,
                             input logic [2:0] col);
        P1blk_h = h1; P1blk_v = v1;
        P2blk_h = h2; P2blk_v = v2;
        P3blk_h = h3; P3blk_v = v3;
        P4blk_h = h4; P4blk_v = v4;
        volatile_blk_color = col;
    endtask

    // Drives one request, waits for the answer (bounded), and scores it.
    task automatic request(input logic intent, input int exp, input string name);
        int got, at, e, limit;
        bit multi;
        exp_q.push_back(exp);
        got = RSP_NONE; at = -1; multi = 1'b0;
        limit = (exp == RSP_NONE) ? 100 : 300;
        movement_intent = intent;
        movement_request = 1'b1;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if ((int'(movement_commit) + int'(movement_declined) + int'(movement_steal)) > 1)
                multi = 1'b1;
            if (got == RSP_NONE) begin
                if (movement_commit)        begin got = RSP_COMMIT;   at = c; end
                else if (movement_declined) begin got = RSP_DECLINED; at = c; end
                else if (movement_steal)    begin got = RSP_STEAL;    at = c; end
            end
            if (got != RSP_NONE && exp != RSP_NONE) break;
        end
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s response: got %0d required %0d", name, got, e);
        end
        vectors++;
        if (multi) begin
            miscompares++;
            $display("FAIL %s exclusive pulses: got multiple required one", name);
        end
        if (got == RSP_COMMIT || got == RSP_DECLINED) begin
            vectors++;
            if (at != 1) begin
                miscompares++;
                $display("FAIL %s latency: got %0d required 1", name, at);
            end
        end
        if (got != RSP_NONE) begin
            @(negedge clk);
            vectors++;
            if ({movement_commit, movement_declined, movement_steal} !== 3'b000) begin
                miscompares++;
                $display("FAIL %s pulse width: got %b required 000", name,
                         {movement_commit, movement_declined, movement_steal});
            end
        end
        movement_request = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_disp(input logic [4:0] h, v, input logic [2:0] exp, input string name);
        disp_h = h; disp_v = v;
        @(negedge clk);
        vectors++;
        if (disp_color !== exp) begin
            miscompares++;
            $display("FAIL %s disp(%0d,%0d): got %0d required %0d", name, h, v, disp_color, exp);
        end
    endtask

    task automatic check_field_empty(input string name);
        int bad;
        bad = 0;
        for (int h = 0; h < 20; h++) begin
            for (int v = 0; v < 10; v++) begin
                disp_h = 5'(h); disp_v = 5'(v);
                @(negedge clk);
                if (disp_color !== 3'd0) bad++;
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s field empty: got %0d occupied cells required 0", name, bad);
        end
    endtask

    task automatic check_lines(input logic [9:0] exp, input string name);
        vectors++;
        if (lines_cleared !== exp) begin
            miscompares++;
            $display("FAIL %s lines_cleared: got %0d required %0d", name, lines_cleared, exp);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({movement_commit, movement_declined, movement_steal, game_over, lines_cleared, disp_color} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got %b required 0",
                     {movement_commit, movement_declined, movement_steal, game_over, lines_cleared, disp_color});
        end
    endtask

    task automatic test_commit();
        set_piece(5'd2, 5'd5, 5'd2, 5'd6, 5'd2, 5'd7, 5'd2, 5'd8, 3'd1);
        request(1'b0, RSP_COMMIT, "commit");
        // Answered promptly again, so the arbiter is back in IDLE.
        set_piece(5'd3, 5'd5, 5'd3, 5'd6, 5'd3, 5'd7, 5'd3, 5'd8, 3'd1);
        request(1'b0, RSP_COMMIT, "commit_again");
    endtask

    task automatic test_declined();
        set_piece(5'd3, 5'd31, 5'd3, 5'd0, 5'd3, 5'd1, 5'd3, 5'd2, 3'd1);
        request(1'b1, RSP_DECLINED, "declined");
        check_field_empty("declined");
    endtask

    task automatic test_lock();
        apply_reset();
        set_piece(5'd19, 5'd3, 5'd19, 5'd4, 5'd19, 5'd5, 5'd18, 5'd4, 3'd3);
        request(1'b0, RSP_COMMIT, "lock_commit");
        set_piece(5'd20, 5'd3, 5'd20, 5'd4, 5'd20, 5'd5, 5'd19, 5'd4, 3'd3);
        request(1'b0, RSP_STEAL, "lock_steal");
        check_disp(5'd19, 5'd4, 3'd3, "lock");
        check_disp(5'd18, 5'd4, 3'd3, "lock");
        check_disp(5'd19, 5'd6, 3'd0, "lock");
        check_disp(5'd20, 5'd4, 3'd0, "lock_oob_row");
        check_disp(5'd19, 5'd10, 3'd0, "lock_oob_col");
        check_lines(10'd0, "lock");
    endtask

    task automatic test_line_clear();
        apply_reset();
        set_piece(5'd19, 5'd0, 5'd19, 5'd1, 5'd19, 5'd2, 5'd18, 5'd0, 3'd2);
        request(1'b0, RSP_COMMIT, "clr_a_commit");
        set_piece(5'd20, 5'd0, 5'd20, 5'd1, 5'd20, 5'd2, 5'd19, 5'd0, 3'd2);
        request(1'b0, RSP_STEAL, "clr_a_steal");
        set_piece(5'd19, 5'd3, 5'd19, 5'd4, 5'd19, 5'd5, 5'd19, 5'd5, 3'd4);
        request(1'b0, RSP_COMMIT, "clr_b_commit");
        set_piece(5'd20, 5'd3, 5'd20, 5'd4, 5'd20, 5'd5, 5'd20, 5'd5, 3'd4);
        request(1'b0, RSP_STEAL, "clr_b_steal");
        set_piece(5'd19, 5'd6, 5'd19, 5'd7, 5'd19, 5'd8, 5'd19, 5'd9, 3'd5);
        request(1'b0, RSP_COMMIT, "clr_i_commit");
        set_piece(5'd20, 5'd6, 5'd20, 5'd7, 5'd20, 5'd8, 5'd20, 5'd9, 3'd5);
        request(1'b0, RSP_STEAL, "clr_i_steal");
        check_lines(10'd1, "clear");
        check_disp(5'd19, 5'd0, 3'd2, "clear_shifted");
        check_disp(5'd19, 5'd1, 3'd0, "clear");
        check_disp(5'd19, 5'd9, 3'd0, "clear");
        check_disp(5'd18, 5'd0, 3'd0, "clear");
    endtask

    task automatic test_game_over();
        set_piece(5'd20, 5'd4, 5'd20, 5'd5, 5'd20, 5'd6, 5'd20, 5'd7, 3'd6);
        request(1'b0, RSP_NONE, "game_over_silent");
        vectors++;
        if (game_over !== 1'b1) begin
            miscompares++;
            $display("FAIL game_over set: got %b required 1", game_over);
        end
        set_piece(5'd5, 5'd4, 5'd5, 5'd5, 5'd5, 5'd6, 5'd5, 5'd7, 3'd6);
        request(1'b1, RSP_NONE, "game_over_ignored");
        apply_reset();
        vectors++;
        if (game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL game_over cleared: got %b required 0", game_over);
        end
        check_lines(10'd0, "game_over_reset");
        check_field_empty("game_over_reset");
    endtask

    task automatic test_reset_mid_scan();
        apply_reset();
        set_piece(5'd19, 5'd0, 5'd19, 5'd1, 5'd19, 5'd2, 5'd19, 5'd3, 3'd1);
        request(1'b0, RSP_COMMIT, "scan_a_commit");
        set_piece(5'd20, 5'd0, 5'd20, 5'd1, 5'd20, 5'd2, 5'd20, 5'd3, 3'd1);
        request(1'b0, RSP_STEAL, "scan_a_steal");
        set_piece(5'd19, 5'd4, 5'd19, 5'd5, 5'd19, 5'd6, 5'd19, 5'd7, 3'd2);
        request(1'b0, RSP_COMMIT, "scan_b_commit");
        set_piece(5'd20, 5'd4, 5'd20, 5'd5, 5'd20, 5'd6, 5'd20, 5'd7, 3'd2);
        request(1'b0, RSP_STEAL, "scan_b_steal");
        set_piece(5'd19, 5'd8, 5'd19, 5'd9, 5'd18, 5'd8, 5'd18, 5'd9, 3'd3);
        request(1'b0, RSP_COMMIT, "scan_c_commit");
        // Natural drop blocked: CHECK, LOCK, then SCAN sees row 19 full.
        set_piece(5'd20, 5'd8, 5'd20, 5'd9, 5'd19, 5'd8, 5'd19, 5'd9, 3'd3);
        disp_h = 5'd19; disp_v = 5'd0;
        movement_intent = 1'b0;
        movement_request = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if ({movement_commit, movement_declined, movement_steal, game_over, lines_cleared, disp_color} !== '0) begin
            miscompares++;
            $display("FAIL mid_scan reset outputs: got %b required 0",
                     {movement_commit, movement_declined, movement_steal, game_over, lines_cleared, disp_color});
        end
        movement_request = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_field_empty("mid_scan");
        check_lines(10'd0, "mid_scan");
        set_piece(5'd10, 5'd1, 5'd10, 5'd2, 5'd11, 5'd1, 5'd11, 5'd2, 3'd7);
        request(1'b0, RSP_COMMIT, "mid_scan_recover");
    endtask

    initial begin
        test_reset();
        test_commit();
        test_declined();
        test_lock();
        test_line_clear();
        test_game_over();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
